coeff_bank_ctrl: RTL and testbench

COEFF_BANK_CTRL -- requirements
Module: coeff_bank_ctrl

---
 rtl/coeff_bank_ctrl_if.sv | 12 +
 rtl/coeff_bank_ctrl.sv | 141 ++++++++++++++
 tb/tb_coeff_bank_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/coeff_bank_ctrl_if.sv
// Register write bus for the coefficient bank controller.
// A write is one cycle with wr_en high; there is no back-pressure, so the
// slave accepts (or deliberately drops) every strobed beat on that edge.
interface coeff_bank_ctrl_if;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  modport master (output wr_addr, output wr_en, output wr_data, output wr_strb);
  modport slave  (input  wr_addr, input  wr_en, input  wr_data, input  wr_strb);
endinterface

// File: rtl/coeff_bank_ctrl.sv
// Double-buffered 5x5 filter coefficient bank: software fills the shadow bank,
// COMMIT arms a swap at the next frame_start, then the new active bank is copied back.
module coeff_bank_ctrl #(
  parameter int NUM_COEFF = 25,
  parameter int COEFF_W   = 16
) (
  input  logic                           rx_clk,
  input  logic                           rst_n,
  coeff_bank_ctrl_if.slave               bus,
  input  logic                           frame_start,
  output logic [NUM_COEFF*COEFF_W-1:0]   coeff_flat,
  output logic                           active_bank,
  output logic                           busy,
  output logic                           swap_done,
  output logic                           wr_err,
  output logic [1:0]                     dbg_state_o
);

  localparam int              IDX_W     = $clog2(NUM_COEFF);
  localparam logic [5:0]      CTRL_WORD = 6'(NUM_COEFF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_COPY = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   active_q, active_d;
  logic                   busy_q, busy_d;
  logic                   swap_q, swap_d;
  logic                   err_q, err_d;
  logic [COEFF_W-1:0]     bank_q [2][NUM_COEFF];

  logic [5:0]             word;
  logic [IDX_W-1:0]       word_idx;
  logic                   coef_hit, ctrl_hit;
  logic                   cmd_commit, cmd_abort, cmd_clr;
  logic                   shadow_wr, copy_en;
  logic [15:0]            lane_mask;
  logic [COEFF_W-1:0]     merged;
  logic                   unused_bits;

  assign word       = bus.wr_addr[7:2];
  assign word_idx   = bus.wr_addr[IDX_W+1:2];
  assign coef_hit   = bus.wr_en && (word < CTRL_WORD);
  assign ctrl_hit   = bus.wr_en && (word == CTRL_WORD) && bus.wr_strb[0];
  assign cmd_commit = ctrl_hit && bus.wr_data[0];
  assign cmd_abort  = ctrl_hit && bus.wr_data[1];
  assign cmd_clr    = ctrl_hit && bus.wr_data[2];
  assign unused_bits = ^{bus.wr_data[31:16], bus.wr_strb[3:2], bus.wr_addr[1:0]};

  // Only the two low byte lanes carry coefficient bits.
  assign lane_mask = {{8{bus.wr_strb[1]}}, {8{bus.wr_strb[0]}}};
  assign merged    = (bank_q[~active_q][word_idx] & ~COEFF_W'(lane_mask)) |
                     (COEFF_W'(bus.wr_data[15:0]) & COEFF_W'(lane_mask));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    swap_d    = 1'b0;
    copy_en   = 1'b0;
    shadow_wr = coef_hit && (state_q == S_IDLE);
    err_d     = err_q;
    if (cmd_clr) err_d = 1'b0;
    // A dropped write wins over a same-cycle clear so the loss is never hidden.
    if (coef_hit && (state_q != S_IDLE)) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cmd_commit) state_d = S_PEND;
      end
      S_PEND: begin
        if (frame_start) begin
          active_d = ~active_q;
          swap_d   = 1'b1;
          idx_d    = '0;
          state_d  = S_COPY;
        end else if (cmd_abort) begin
          state_d = S_IDLE;
        end
      end
      S_COPY: begin
        copy_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
    end
  end

  // Copy-back keeps the shadow equal to the live set so partial edits start from it.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_COEFF; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      if (shadow_wr) bank_q[~active_q][word_idx] <= merged;
      if (copy_en)   bank_q[~active_q][idx_q]    <= bank_q[active_q][idx_q];
    end
  end

  for (genvar g = 0; g < NUM_COEFF; g++) begin : g_flat
    assign coeff_flat[g*COEFF_W +: COEFF_W] = bank_q[active_q][g];
  end

  assign active_bank = active_q;
  assign busy        = busy_q;
  assign swap_done   = swap_q;
  assign wr_err      = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Bench for coeff_bank_ctrl: directed scenarios plus random traffic, every
// cycle compared against a bank/pending/copy-countdown reference model.
module tb_coeff_bank_ctrl;
  localparam int N  = 25;
  localparam int W  = 16;
  localparam int FW = N * W;

  logic          rx_clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [FW-1:0] coeff_flat;
  logic          active_bank, busy, swap_done, wr_err;
  logic [1:0]    dbg_state;

  coeff_bank_ctrl_if bus();

  coeff_bank_ctrl #(.NUM_COEFF(N), .COEFF_W(W)) dut (
    .rx_clk      (rx_clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_start (frame_start),
    .coeff_flat  (coeff_flat),
    .active_bank (active_bank),
    .busy        (busy),
    .swap_done   (swap_done),
    .wr_err      (wr_err),
    .dbg_state_o (dbg_state)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: two banks, a pending-swap flag, and a countdown of copy cycles left.
  logic [W-1:0] m_bank [2][N];
  bit           m_act, m_pend, m_swap, m_err;
  int           m_copy_left;

  task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_bank[m_act][i];
    return f;
  endfunction

  function automatic logic [W-1:0] coeff_at(input int i);
    return coeff_flat[i*W +: W];
  endfunction

  task automatic model_step(input logic [7:0] a, input logic en, input logic [31:0] d,
                            input logic [3:0] s, input logic fs, input logic rn);
    int  w;
    bit  coef, ctrl, was_busy;
    w = int'(a[7:2]);
    m_swap = 0;
    if (!rn) begin
      for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_bank[b][i] = '0;
      m_act = 0; m_pend = 0; m_err = 0; m_copy_left = 0;
      return;
    end
    coef = en && (w < N);
    ctrl = en && (w == 25) && s[0];
    was_busy = m_pend || (m_copy_left > 0);
    if (ctrl && d[2]) m_err = 0;
    if (coef && was_busy) m_err = 1;
    if (coef && !was_busy) begin
      if (s[0]) m_bank[!m_act][w][7:0]  = d[7:0];
      if (s[1]) m_bank[!m_act][w][15:8] = d[15:8];
    end
    if (m_copy_left > 0) begin
      m_bank[!m_act][N - m_copy_left] = m_bank[m_act][N - m_copy_left];
      m_copy_left--;
    end else if (m_pend) begin
      if (fs) begin
        m_act = !m_act; m_swap = 1; m_pend = 0; m_copy_left = N;
      end else if (ctrl && d[1]) begin
        m_pend = 0;
      end
    end else if (ctrl && d[0]) begin
      m_pend = 1;
    end
  endtask

  task automatic cycle(input logic [7:0] a, input logic en, input logic [31:0] d,
                       input logic [3:0] s, input logic fs, input logic rn);
    bus.wr_addr = a; bus.wr_en = en; bus.wr_data = d; bus.wr_strb = s;
    frame_start = fs; rst_n = rn;
    @(posedge rx_clk);
    model_step(a, en, d, s, fs, rn);
    #1;
    check_eq("coeff_flat",  coeff_flat,        exp_flat());
    check_eq("active_bank", FW'(active_bank),  FW'(m_act));
    check_eq("busy",        FW'(busy),         FW'(m_pend || (m_copy_left > 0)));
    check_eq("swap_done",   FW'(swap_done),    FW'(m_swap));
    check_eq("wr_err",      FW'(wr_err),       FW'(m_err));
    @(negedge rx_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic wr_word(input int w, input logic [31:0] d, input logic [3:0] s);
    cycle({6'(w), 2'b00}, 1'b1, d, s, 1'b0, 1'b1);
  endtask

  task automatic ctrl_cmd(input logic [2:0] cmd, input logic fs);
    cycle(8'h64, 1'b1, {29'h0, cmd}, 4'h1, fs, 1'b1);
  endtask

  task automatic pulse_fs();
    cycle(8'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
  endtask

  initial begin
    bus.wr_addr = '0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_strb = '0;
    frame_start = 1'b0; rst_n = 1'b0;

    // Reset with traffic that must be ignored.
    cycle(8'h00, 1'b1, 32'h1234, 4'hF, 1'b1, 1'b0);
    cycle(8'h64, 1'b1, 32'h1,    4'h1, 1'b1, 1'b0);
    check_eq("reset_flat", coeff_flat, '0);
    check_eq("reset_busy", FW'(busy), '0);
    idle(2);

    // Full load, commit, swap, copy-back timing.
    for (int i = 0; i < N; i++) wr_word(i, 32'(i + 1), 4'h3);
    ctrl_cmd(3'b001, 1'b0);
    idle(3);
    pulse_fs();
    check_eq("load_c0",   FW'(coeff_at(0)),  FW'(16'd1));
    check_eq("load_c24",  FW'(coeff_at(24)), FW'(16'd25));
    check_eq("load_act",  FW'(active_bank),  FW'(1'b1));
    check_eq("load_swap", FW'(swap_done),    FW'(1'b1));
    idle(1);
    check_eq("load_swap_once", FW'(swap_done), '0);
    idle(23);
    check_eq("copy_busy_t25", FW'(busy), FW'(1'b1));
    idle(1);
    check_eq("copy_busy_t26", FW'(busy), '0);
    idle(3);

    // Single-coefficient edit on top of the copied-back set.
    wr_word(12, 32'h0000FFFF, 4'h3);
    ctrl_cmd(3'b001, 1'b0);
    pulse_fs();
    check_eq("edit_c12", FW'(coeff_at(12)), FW'(16'hFFFF));
    check_eq("edit_c11", FW'(coeff_at(11)), FW'(16'd12));
    check_eq("edit_c13", FW'(coeff_at(13)), FW'(16'd14));
    idle(30);

    // Byte-lane strobes.
    wr_word(3, 32'h00005500, 4'h3);
    wr_word(3, 32'hABCD1234, 4'h1);
    wr_word(3, 32'hFFFFFFFF, 4'hC);
    ctrl_cmd(3'b001, 1'b0);
    pulse_fs();
    check_eq("strb_c3", FW'(coeff_at(3)), FW'(16'h5534));
    idle(30);

    // Dropped write, error clear, abort.
    ctrl_cmd(3'b001, 1'b0);
    wr_word(5, 32'h00007777, 4'h3);
    check_eq("drop_err", FW'(wr_err), FW'(1'b1));
    ctrl_cmd(3'b100, 1'b0);
    check_eq("clr_err", FW'(wr_err), '0);
    ctrl_cmd(3'b010, 1'b0);
    pulse_fs();
    check_eq("abort_noswap", FW'(swap_done), '0);
    check_eq("abort_c5",     FW'(coeff_at(5)), FW'(16'd6));
    check_eq("abort_c3",     FW'(coeff_at(3)), FW'(16'h5534));
    idle(2);

    // Commit coinciding with frame_start, then reset in the middle of COPY.
    ctrl_cmd(3'b001, 1'b1);
    check_eq("cf_noswap", FW'(swap_done), '0);
    idle(2);
    pulse_fs();
    check_eq("cf_swap", FW'(swap_done), FW'(1'b1));
    idle(9);
    cycle(8'h00, 1'b1, 32'h0000BEEF, 4'h3, 1'b1, 1'b0);
    check_eq("midcopy_flat",  coeff_flat, '0);
    check_eq("midcopy_act",   FW'(active_bank), '0);
    check_eq("midcopy_busy",  FW'(busy), '0);
    check_eq("midcopy_state", FW'(dbg_state), '0);
    idle(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        en, fs, rn;
      r  = $urandom_range(0, 99);
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      en = 1'b1;
      if (r < 30)      a = {6'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3))};
      else if (r < 42) begin a = 8'h64 | 8'($urandom_range(0, 3)); d = {29'h0, 3'($urandom_range(0, 7))}; end
      else if (r < 47) a = 8'($urandom_range(0, 255));
      else begin a = 8'($urandom_range(0, 255)); en = 1'b0; end
      fs = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 399) != 0);
      cycle(a, en, d, s, fs, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
